// File: rtl/sram_mem_controller_pkg.sv
// -----------------------------------------------------------------------------
// sram_mem_controller_pkg
//   Shared definitions for the MEM-stage SRAM controller: FSM state encoding,
//   default parameter values and the wait-counter width helper.
// -----------------------------------------------------------------------------
package sram_mem_controller_pkg;

    // Access sequencer states. The encoding is fixed so it can be decoded
    // directly on a debug bus.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned DEF_WAIT_CYCLES = 2;
    localparam int unsigned DEF_BASE_ADDR   = 1024;
    localparam int unsigned DEF_SRAM_AW     = 18;

    // Width of a counter that must reach wait_cycles-1. A single-cycle phase
    // still gets a 1-bit counter so the port widths never collapse to zero.
    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return (wait_cycles <= 1) ? 1 : $clog2(wait_cycles);
    endfunction

endpackage

// File: rtl/sram_mem_controller_wait_counter.sv
// -----------------------------------------------------------------------------
// sram_wait_counter
//   Counts the cycles of one SRAM halfword phase.
//   Ports:
//     clk, rst   clock / asynchronous active-high reset
//     clear      force the count back to 0 (phase boundary)
//     en         advance the count while a phase is in progress
//     last       high while the count equals WAIT_CYCLES-1
// -----------------------------------------------------------------------------
module sram_wait_counter
    import sram_mem_controller_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last
);

    localparam int unsigned    CW       = cnt_width(WAIT_CYCLES);
    localparam logic [CW-1:0]  LAST_VAL = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] count;

    // Saturates at LAST_VAL; the FSM clears it when it leaves the phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !last) begin
            count <= count + CW'(1);
        end
    end

    assign last = (count == LAST_VAL);

endmodule

// File: rtl/sram_mem_controller.sv
// -----------------------------------------------------------------------------
// sram_mem_controller
//   Turns a MEM-stage 32-bit LDR/STR into two halfword accesses (low, then
//   high) on a 16-bit asynchronous SRAM, each phase WAIT_CYCLES long, and
//   stalls the pipeline through ready while the access is in flight.
//   Ports:
//     clk, rst          clock / asynchronous active-high reset
//     rd_en, wr_en      LDR / STR request from the MEM stage (write wins)
//     address           CPU byte address; BASE_ADDR maps to SRAM halfword 0
//     write_data        STR data
//     read_data         registered LDR result, held until the next read
//     ready             1 = MEM stage may advance
//     sram_addr         SRAM halfword address
//     sram_dq_out/_in   DQ bus write / read data
//     sram_dq_oe        1 = drive DQ
//     sram_we_n/_oe_n   SRAM write / output enables, active low
// -----------------------------------------------------------------------------
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = 32'(DEF_BASE_ADDR),
    parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    state_t state, state_n;

    logic                 req;
    logic                 last;
    logic                 cnt_clear;
    logic                 cnt_en;

    // Access latched on IDLE exit.
    logic                 op_wr_q;
    logic [SRAM_AW-2:0]   word_q;
    logic [31:0]          wdata_q;
    logic [15:0]          rdata_lo_q;

    // Access description used to build the registered SRAM pins for the
    // next cycle: the live request while in IDLE, the latched one otherwise.
    logic [31:0]          eff_full;
    logic                 src_wr;
    logic [SRAM_AW-2:0]   src_word;
    logic [31:0]          src_wdata;
    logic                 unused_eff;

    assign req      = rd_en | wr_en;
    assign eff_full = address - BASE_ADDR;
    assign unused_eff = ^{eff_full[31:SRAM_AW+1], eff_full[1:0]};

    always_comb begin
        src_wr    = op_wr_q;
        src_word  = word_q;
        src_wdata = wdata_q;
        if (state == ST_IDLE) begin
            src_wr    = wr_en;
            src_word  = eff_full[SRAM_AW:2];
            src_wdata = write_data;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = ~req;
                if (req) state_n = ST_LOW;
            end
            ST_LOW: begin
                if (last) state_n = ST_HIGH;
            end
            ST_HIGH: begin
                if (last) state_n = ST_DONE;
            end
            ST_DONE: begin
                // Requests are ignored here: the MEM stage advances on this
                // edge, so rd_en/wr_en still belong to the finished access.
                ready   = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Every state change restarts the phase count at 0.
    assign cnt_clear = (state_n != state);
    assign cnt_en    = (state == ST_LOW) || (state == ST_HIGH);

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (cnt_en),
        .last  (last)
    );

    // ------------------------------------------------------------------
    // Access latch and read data assembly
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr_q    <= 1'b0;
            word_q     <= '0;
            wdata_q    <= '0;
            rdata_lo_q <= '0;
            read_data  <= '0;
        end else begin
            if (state == ST_IDLE && req) begin
                op_wr_q <= wr_en;
                word_q  <= eff_full[SRAM_AW:2];
                wdata_q <= write_data;
            end
            if (state == ST_LOW && last && !op_wr_q) begin
                rdata_lo_q <= sram_dq_in;
            end
            // The word is written on the HIGH->DONE edge so that read_data
            // already holds it during the DONE cycle, when ready rises.
            if (state == ST_HIGH && last && !op_wr_q) begin
                read_data <= {sram_dq_in, rdata_lo_q};
            end
        end
    end

    // ------------------------------------------------------------------
    // SRAM pins: registered from the next state so they only move on
    // phase boundaries and come out of flops.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            case (state_n)
                ST_LOW: begin
                    sram_addr <= {src_word, 1'b0};
                    if (src_wr) begin
                        sram_we_n   <= 1'b0;
                        sram_dq_oe  <= 1'b1;
                        sram_dq_out <= src_wdata[15:0];
                    end else begin
                        sram_oe_n   <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    sram_addr <= {src_word, 1'b1};
                    if (src_wr) begin
                        sram_we_n   <= 1'b0;
                        sram_dq_oe  <= 1'b1;
                        sram_dq_out <= src_wdata[31:16];
                    end else begin
                        sram_oe_n   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
